// File: rtl/user_input_conditioner.sv
// Per-channel input conditioner: 2-flop synchroniser, polarity normalisation,
// debounce FSM and edge/auto-repeat pulse generation with registered outputs.
module user_input_conditioner #(
  parameter int N             = 4,
  parameter int DB_CYCLES     = 4,
  parameter int ACTIVE_LOW    = 1,
  parameter int EDGE_MODE     = 0,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [N-1:0] in,
  output logic [N-1:0] pressed,
  output logic [N-1:0] pulse,
  output logic         any_pulse
);

  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    CONFIRM_PRESS   = 2'd1,
    PRESSED         = 2'd2,
    CONFIRM_RELEASE = 2'd3
  } state_t;

  localparam int DBW     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPTW    = $clog2(RPT_MAX + 1);

  localparam bit RPT_EN           = (REPEAT_DELAY > 0) && (EDGE_MODE != 1);
  localparam bit PULSE_ON_PRESS   = (EDGE_MODE != 1);
  localparam bit PULSE_ON_RELEASE = (EDGE_MODE != 0);
  localparam logic REL_LVL        = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  localparam logic [DBW-1:0]  DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [RPTW-1:0] RPT_FIRST = RPTW'(REPEAT_DELAY);
  localparam logic [RPTW-1:0] RPT_NEXT  = RPTW'(REPEAT_PERIOD);

  function automatic logic is_held(input state_t st);
    return (st == PRESSED) || (st == CONFIRM_RELEASE);
  endfunction

  logic [N-1:0] pulse_nxt_s;
  logic         any_pulse_r;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [1:0]      sync_r;
    state_t          state_r, state_nxt_s;
    logic [DBW-1:0]  db_cnt_r, db_cnt_nxt_s;
    logic [RPTW-1:0] rpt_cnt_r, rpt_cnt_nxt_s, rpt_inc_s;
    logic            rpt_phase_r, rpt_phase_nxt_s;
    logic            press_s, held_nxt_s, press_evt_s, release_evt_s, rpt_due_s;
    logic            pressed_r, pulse_r;

    assign press_s = sync_r[1] ^ REL_LVL;

    // Debounce FSM: a level must persist DB_CYCLES synchronised cycles to be accepted
    always_comb begin
      state_nxt_s  = state_r;
      db_cnt_nxt_s = db_cnt_r;
      case (state_r)
        RELEASED: begin
          if (press_s) begin
            if (DB_CYCLES == 1) begin
              state_nxt_s = PRESSED;
            end else begin
              state_nxt_s  = CONFIRM_PRESS;
              db_cnt_nxt_s = DBW'(1);
            end
          end else begin
            state_nxt_s = RELEASED;
          end
        end
        CONFIRM_PRESS: begin
          if (!press_s) begin
            state_nxt_s  = RELEASED;
            db_cnt_nxt_s = '0;
          end else if (db_cnt_r == DB_LAST) begin
            state_nxt_s  = PRESSED;
            db_cnt_nxt_s = '0;
          end else begin
            db_cnt_nxt_s = db_cnt_r + DBW'(1);
          end
        end
        PRESSED: begin
          if (!press_s) begin
            if (DB_CYCLES == 1) begin
              state_nxt_s = RELEASED;
            end else begin
              state_nxt_s  = CONFIRM_RELEASE;
              db_cnt_nxt_s = DBW'(1);
            end
          end else begin
            state_nxt_s = PRESSED;
          end
        end
        CONFIRM_RELEASE: begin
          if (press_s) begin
            state_nxt_s  = PRESSED;
            db_cnt_nxt_s = '0;
          end else if (db_cnt_r == DB_LAST) begin
            state_nxt_s  = RELEASED;
            db_cnt_nxt_s = '0;
          end else begin
            db_cnt_nxt_s = db_cnt_r + DBW'(1);
          end
        end
        default: begin
          state_nxt_s  = RELEASED;
          db_cnt_nxt_s = '0;
        end
      endcase
    end

    // Edge events and auto-repeat; a repeat falling due as the key releases is dropped
    always_comb begin
      held_nxt_s      = is_held(state_nxt_s);
      press_evt_s     = held_nxt_s && !pressed_r;
      release_evt_s   = !held_nxt_s && pressed_r;
      rpt_inc_s       = rpt_cnt_r + RPTW'(1);
      rpt_due_s       = 1'b0;
      rpt_cnt_nxt_s   = rpt_cnt_r;
      rpt_phase_nxt_s = rpt_phase_r;
      if (!RPT_EN || !held_nxt_s || press_evt_s) begin
        rpt_cnt_nxt_s   = '0;
        rpt_phase_nxt_s = 1'b0;
      end else if (!rpt_phase_r && (rpt_inc_s == RPT_FIRST)) begin
        rpt_due_s       = 1'b1;
        rpt_cnt_nxt_s   = '0;
        rpt_phase_nxt_s = 1'b1;
      end else if (rpt_phase_r && (rpt_inc_s == RPT_NEXT)) begin
        rpt_due_s     = 1'b1;
        rpt_cnt_nxt_s = '0;
      end else begin
        rpt_cnt_nxt_s = rpt_inc_s;
      end
    end

    assign pulse_nxt_s[i] = (press_evt_s & PULSE_ON_PRESS)
                          | (release_evt_s & PULSE_ON_RELEASE)
                          | rpt_due_s;

    // Channel state and registered outputs; reset loads the released level
    always_ff @(posedge Clock) begin
      if (Reset) begin
        sync_r      <= {REL_LVL, REL_LVL};
        state_r     <= RELEASED;
        db_cnt_r    <= '0;
        rpt_cnt_r   <= '0;
        rpt_phase_r <= 1'b0;
        pressed_r   <= 1'b0;
        pulse_r     <= 1'b0;
      end else begin
        sync_r      <= {sync_r[0], in[i]};
        state_r     <= state_nxt_s;
        db_cnt_r    <= db_cnt_nxt_s;
        rpt_cnt_r   <= rpt_cnt_nxt_s;
        rpt_phase_r <= rpt_phase_nxt_s;
        pressed_r   <= held_nxt_s;
        pulse_r     <= pulse_nxt_s[i];
      end
    end

    assign pressed[i] = pressed_r;
    assign pulse[i]   = pulse_r;
  end

  // Summary strobe registered alongside the per-channel pulses
  always_ff @(posedge Clock) begin
    if (Reset) begin
      any_pulse_r <= 1'b0;
    end else begin
      any_pulse_r <= |pulse_nxt_s;
    end
  end

  assign any_pulse = any_pulse_r;

endmodule

// File: tb/tb_user_input_conditioner.sv
// Directed bench for user_input_conditioner: press-only instance with
// auto-repeat and a both-edges instance sharing clock and reset.
module tb_user_input_conditioner;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [3:0] in_a, in_b;
  logic [3:0] pressed_a, pulse_a, pressed_b, pulse_b;
  logic       any_a, any_b;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 Clock = ~Clock;

  user_input_conditioner #(
    .N(4), .DB_CYCLES(4), .ACTIVE_LOW(1), .EDGE_MODE(0),
    .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) dut_a (
    .Clock(Clock), .Reset(Reset), .in(in_a),
    .pressed(pressed_a), .pulse(pulse_a), .any_pulse(any_a)
  );

  user_input_conditioner #(
    .N(4), .DB_CYCLES(4), .ACTIVE_LOW(1), .EDGE_MODE(2),
    .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) dut_b (
    .Clock(Clock), .Reset(Reset), .in(in_b),
    .pressed(pressed_b), .pulse(pulse_b), .any_pulse(any_b)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1;
    in_a  = 4'hF;
    in_b  = 4'hF;
    tick();
    tick();
    check_value("rst_pressed_a", pressed_a, 4'h0);
    check_value("rst_pulse_a",   pulse_a,   4'h0);
    check_value("rst_any_a",     any_a,     1'b0);
    check_value("rst_pressed_b", pressed_b, 4'h0);
    check_value("rst_pulse_b",   pulse_b,   4'h0);
    Reset = 1'b0;
    repeat (4) tick();
    check_value("idle_pressed_a", pressed_a, 4'h0);

    // Single press on channel 0: level and pulse after 6 edges
    in_a[0] = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check_value("press0_pressed", pressed_a, (e >= 6) ? 4'b0001 : 4'b0000);
      check_value("press0_pulse",   pulse_a,   (e == 6) ? 4'b0001 : 4'b0000);
      check_value("press0_any",     any_a,     (e == 6) ? 1'b1 : 1'b0);
    end
    in_a[0] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check_value("rel0_pressed", pressed_a, (e < 6) ? 4'b0001 : 4'b0000);
      check_value("rel0_pulse",   pulse_a,   4'b0000);
    end

    // Bounce of DB_CYCLES-1 cycles on channel 1 is rejected
    in_a[1] = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 3) in_a[1] = 1'b1;
      check_value("bounce1_pressed", pressed_a, 4'b0000);
      check_value("bounce1_pulse",   pulse_a,   4'b0000);
    end

    // Exactly DB_CYCLES low cycles is accepted as a short press
    in_a[1] = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 4) in_a[1] = 1'b1;
      check_value("short1_pressed", pressed_a, (e >= 6 && e <= 9) ? 4'b0010 : 4'b0000);
      check_value("short1_pulse",   pulse_a,   (e == 6) ? 4'b0010 : 4'b0000);
    end

    // Hold channel 2: repeats at P+20, +28, +36, +44; release lands on a due cycle
    in_a[2] = 1'b0;
    repeat (5) tick();
    check_value("hold2_pre", pulse_a, 4'b0000);
    tick();
    check_value("hold2_P", pulse_a, 4'b0100);
    for (int j = 1; j <= 46; j++) begin
      tick();
      check_value("hold2_pulse", pulse_a,
                  (j == 20 || j == 28 || j == 36 || j == 44) ? 4'b0100 : 4'b0000);
      check_value("hold2_pressed", pressed_a, 4'b0100);
    end
    in_a[2] = 1'b1;
    for (int j = 47; j <= 58; j++) begin
      tick();
      check_value("hold2_rel_pulse",   pulse_a,   4'b0000);
      check_value("hold2_rel_pressed", pressed_a, (j < 52) ? 4'b0100 : 4'b0000);
    end

    // Repeat timing restarts from zero on a fresh press
    in_a[2] = 1'b0;
    repeat (5) tick();
    tick();
    check_value("rehold2_P", pulse_a, 4'b0100);
    for (int j = 1; j <= 21; j++) begin
      tick();
      check_value("rehold2_pulse", pulse_a, (j == 20) ? 4'b0100 : 4'b0000);
    end
    in_a[2] = 1'b1;
    repeat (8) tick();
    check_value("rehold2_released", pressed_a, 4'b0000);

    // Simultaneous press on channels 0 and 3
    in_a = 4'b0110;
    repeat (5) tick();
    check_value("multi_pre", pulse_a, 4'b0000);
    tick();
    check_value("multi_pulse", pulse_a, 4'b1001);
    check_value("multi_any",   any_a,   1'b1);
    tick();
    check_value("multi_after_pulse", pulse_a, 4'b0000);
    check_value("multi_after_any",   any_a,   1'b0);
    in_a = 4'hF;
    repeat (8) tick();
    check_value("multi_released", pressed_a, 4'b0000);

    // Both-edges instance: press then release on channel 3
    in_b[3] = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check_value("both3_press_pressed", pressed_b, (e >= 6) ? 4'b1000 : 4'b0000);
      check_value("both3_press_pulse",   pulse_b,   (e == 6) ? 4'b1000 : 4'b0000);
    end
    in_b[3] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check_value("both3_rel_pressed", pressed_b, (e < 6) ? 4'b1000 : 4'b0000);
      check_value("both3_rel_pulse",   pulse_b,   (e == 6) ? 4'b1000 : 4'b0000);
      check_value("both3_rel_any",     any_b,     (e == 6) ? 1'b1 : 1'b0);
    end

    // Reset while channel 1 is held: outputs clear, key re-detected as new press
    in_a[1] = 1'b0;
    repeat (6) tick();
    check_value("rsthold_pressed", pressed_a, 4'b0010);
    Reset = 1'b1;
    tick();
    check_value("rsthold_rst_pressed", pressed_a, 4'b0000);
    check_value("rsthold_rst_pulse",   pulse_a,   4'b0000);
    check_value("rsthold_rst_any",     any_a,     1'b0);
    Reset = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check_value("rsthold_pressed_after", pressed_a, (e >= 6) ? 4'b0010 : 4'b0000);
      check_value("rsthold_pulse_after",   pulse_a,   (e == 6) ? 4'b0010 : 4'b0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/user_input_conditioner.md
USER_INPUT_CONDITIONER -- requirements
Module: user_input_conditioner

Interface
REQ-001 Parameter N, default 4: number of independent input channels, 1..32.
REQ-002 Parameter DB_CYCLES, default 4: debounce confirmation length in clock cycles, >= 1.
REQ-003 Parameter ACTIVE_LOW, default 1: 1 = raw input low means pressed; 0 = raw input high means pressed.
REQ-004 Parameter EDGE_MODE, default 0: 0 = pulse on press, 1 = pulse on release, 2 = pulse on both.
REQ-005 Parameter REPEAT_DELAY, default 0: cycles from press pulse to first auto-repeat pulse; 0 disables auto-repeat.
REQ-006 Parameter REPEAT_PERIOD, default 8: cycles between subsequent auto-repeat pulses, >= 1.
REQ-007 Clock  input  1  single clock; all state updates on its rising edge.
REQ-008 Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clock.
REQ-009 in  input  N  raw asynchronous user inputs (keys/switches), one bit per channel.
REQ-010 pressed  output  N  registered debounced level per channel, 1 = pressed, independent of ACTIVE_LOW.
REQ-011 pulse  output  N  registered one-cycle event strobe per channel (edge events and auto-repeat).
REQ-012 any_pulse  output  1  registered OR of all pulse bits, same cycle as pulse.

Function
REQ-013 Each channel SHALL pass in through a 2-flop synchroniser, then polarity-normalise (invert when ACTIVE_LOW=1) to obtain s.
REQ-014 Each channel SHALL run its own FSM: RELEASED, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE, plus a debounce counter sized for DB_CYCLES.
REQ-015 RELEASED: s=1 -> CONFIRM_PRESS with counter=1 (if DB_CYCLES=1, go directly to PRESSED); s=0 -> stay.
REQ-016 CONFIRM_PRESS: s=0 -> RELEASED, counter cleared (bounce rejected, no pulse); s=1 and counter=DB_CYCLES-1 -> PRESSED, counter cleared; else counter+1.
REQ-017 PRESSED / CONFIRM_RELEASE SHALL mirror REQ-015/016 with s inverted.
REQ-018 pressed SHALL be 1 exactly while the FSM is in PRESSED or CONFIRM_RELEASE.
REQ-019 Latency: a clean level change present before rising edge k SHALL change pressed on the output after edge k+DB_CYCLES+1 (DB_CYCLES+2 edges total).
REQ-020 A press event (pressed 0->1) SHALL raise pulse for exactly one cycle, coincident with the first cycle pressed=1, when EDGE_MODE is 0 or 2.
REQ-021 A release event (pressed 1->0) SHALL raise pulse for one cycle, coincident with the first cycle pressed=0, when EDGE_MODE is 1 or 2.
REQ-022 Any input glitch shorter than DB_CYCLES consecutive synchronised cycles SHALL produce no change in pressed and no pulse.
REQ-023 Auto-repeat (REPEAT_DELAY>0, EDGE_MODE 0 or 2 only): with press pulse in cycle P, while pressed stays 1, pulse SHALL also be high in cycles P+REPEAT_DELAY, then every REPEAT_PERIOD cycles after.
REQ-024 The repeat counter SHALL run during CONFIRM_RELEASE, SHALL clear on leaving the pressed level, and SHALL restart at 0 on the next press event; a release during a repeat-due cycle suppresses that repeat pulse.
REQ-025 Auto-repeat in EDGE_MODE 1 SHALL be inert; pulse never asserts during a hold.
REQ-026 Channels SHALL be fully independent; simultaneous events on several channels SHALL assert all corresponding pulse bits in the same cycle.
REQ-027 Counters SHALL never wrap; repeat counter saturates/reloads as defined and is wide enough for max(REPEAT_DELAY, REPEAT_PERIOD).

Reset
REQ-028 While Reset=1 at an edge: synchronisers load the released level, all FSMs go to RELEASED, all counters 0, pressed=0, pulse=0, any_pulse=0.
REQ-029 Reset asserted mid-debounce or mid-hold SHALL abort the operation without emitting any pulse in the reset cycle or the following cycle.
REQ-030 A key held through reset deassertion SHALL be treated as a new press: pulse per REQ-019/020 after DB_CYCLES+2 edges.

Verification (N=4, DB_CYCLES=4, ACTIVE_LOW=1, EDGE_MODE=0, REPEAT_DELAY=20, REPEAT_PERIOD=8 unless stated)
REQ-031 in[0] 1->0 before edge k, held -> pressed[0]=1 and pulse[0]=1 for one cycle after edge k+5; any_pulse matches; other channels stay 0.
REQ-032 in[1] low for 3 cycles then high (bounce) -> pressed[1] and pulse[1] remain 0 throughout.
REQ-033 in[2] held low for 50 cycles from press pulse P -> pulse[2] at P, P+20, P+28, P+36, P+44 only; release -> no pulse (EDGE_MODE=0).
REQ-034 EDGE_MODE=2, in[3] press then release after 10 cycles -> two single-cycle pulses, second coincident with pressed[3] 1->0.
REQ-035 in[0] and in[3] pressed same cycle -> pulse=4'b1001 and any_pulse=1 in the same cycle.
REQ-036 Reset=1 for one cycle while in[1] held pressed and pressed[1]=1 -> all outputs 0 after that edge; pressed[1] and pulse[1] reassert 6 edges after Reset deasserts.
